// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: one fetch request at a time is turned into a
// single AR/R read, and the result is handed back to the fetch unit.
// Redirect flushes and bus timeouts are absorbed here so that the fetch unit
// only ever sees whole results.
//
//   state | meaning
//   IDLE  | waiting for a fetch request (blocked while a stale beat is owed)
//   ADDR  | arvalid up, waiting for arready; a flush is remembered
//   DATA  | rready up, waiting for rvalid, timeout counter running
//   DRAIN | address already issued but fetch cancelled; swallow one R beat
//   HOLD  | result presented to the fetch unit until accepted or flushed
module inst_fetch_bridge #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        cpu_clk,
   input  logic        cpu_rs,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_pc,
   input  logic        flush,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_inst,
   output logic [31:0] resp_pc,
   output logic [1:0]  resp_fault,
   output logic        busy
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_DATA  = 3'd2,
      S_DRAIN = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   inst_q, inst_d;
   logic [1:0]    fault_q, fault_d;
   logic          stale_q, stale_d;
   logic          flush_seen_q, flush_seen_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc = cnt_q + 1'b1;

   // The address bus always shows the latched PC; it only matters while arvalid is up.
   assign araddr     = pc_q;
   assign resp_inst  = inst_q;
   assign resp_pc    = pc_q;
   assign resp_fault = fault_q;
   assign busy       = (state_q != S_IDLE) | stale_q;

   // Next-state, result capture and handshake outputs.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      fault_d      = fault_q;
      stale_d      = stale_q;
      flush_seen_d = flush_seen_q;
      cnt_d        = cnt_q;
      req_ready    = (state_q == S_IDLE) & ~stale_q & ~flush;
      arvalid      = 1'b0;
      rready       = stale_q;
      resp_valid   = 1'b0;

      // A late beat from a timed-out read is swallowed wherever we are.
      if (stale_q && rvalid) begin
         stale_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               pc_d = req_pc;
               if (req_pc[1:0] != 2'b00) begin
                  state_d = S_HOLD;
                  fault_d = 2'd2;
                  inst_d  = '0;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            arvalid = 1'b1;
            if (flush) begin
               flush_seen_d = 1'b1;
            end
            if (arready) begin
               cnt_d        = '0;
               flush_seen_d = 1'b0;
               state_d      = (flush_seen_q || flush) ? S_DRAIN : S_DATA;
            end
         end
         S_DATA: begin
            rready = 1'b1;
            cnt_d  = cnt_inc;
            if (flush) begin
               state_d = rvalid ? S_IDLE : S_DRAIN;
            end else if (rvalid) begin
               state_d = S_HOLD;
               if (rresp != 2'b00) begin
                  fault_d = 2'd1;
                  inst_d  = '0;
               end else begin
                  fault_d = 2'd0;
                  inst_d  = rdata;
               end
            end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
               state_d = S_HOLD;
               fault_d = 2'd3;
               inst_d  = '0;
               stale_d = 1'b1;
            end
         end
         S_DRAIN: begin
            rready = 1'b1;
            if (rvalid) begin
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            resp_valid = ~flush;
            if (flush || resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rs) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         inst_q       <= '0;
         fault_q      <= '0;
         stale_q      <= 1'b0;
         flush_seen_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         fault_q      <= fault_d;
         stale_q      <= stale_d;
         flush_seen_q <= flush_seen_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed scenarios plus randomized fetches
// compared against a latency/result model derived from the bridge rules.
module tb_inst_fetch_bridge;

   localparam int TMO = 4;

   logic        cpu_clk = 1'b0;
   logic        cpu_rs = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_pc = '0;
   logic        flush = 1'b0;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] araddr;
   logic        rvalid = 1'b0;
   logic        rready;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_inst;
   logic [31:0] resp_pc;
   logic [1:0]  resp_fault;
   logic        busy;

   int checks = 0;
   int failures = 0;

   inst_fetch_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .cpu_clk(cpu_clk), .cpu_rs(cpu_rs),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .flush(flush),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_inst(resp_inst), .resp_pc(resp_pc), .resp_fault(resp_fault),
      .busy(busy)
   );

   always #5 cpu_clk = ~cpu_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected fault code from the bridge rules.
   function automatic logic [1:0] model_fault(input logic [31:0] pc, input int r_dly,
                                             input logic [1:0] resp);
      if (pc[1:0] != 2'b00) return 2'd2;
      if (r_dly >= TMO)     return 2'd3;
      if (resp != 2'b00)    return 2'd1;
      return 2'd0;
   endfunction

   task automatic idle_inputs();
      req_valid = 0; flush = 0; arready = 0; rvalid = 0; resp_ready = 0;
   endtask

   task automatic test_reset();
      logic [4:0]  obs;
      logic [97:0] obs_d;
      cpu_rs = 1;
      idle_inputs();
      repeat (2) @(posedge cpu_clk);
      #1 cpu_rs = 0;
      #1;
      obs = {arvalid, rready, resp_valid, req_ready, busy};
      checks++;
      if (obs !== 5'b00010) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=%b", obs, 5'b00010);
      end
      obs_d = {resp_inst, resp_pc, resp_fault, araddr};
      checks++;
      if (obs_d !== '0) begin
         failures++; $display("FAIL reset_data got=%h exp=0", obs_d);
      end
      @(posedge cpu_clk); #1;
   endtask

   // One complete fetch. r_dly >= TMO means memory stays silent.
   task automatic do_fetch(input logic [31:0] pc, input int ar_dly, input int r_dly,
                           input logic [31:0] data, input logic [1:0] resp,
                           input int hold, input string name);
      logic        aligned, tmo, exp_ar, exp_rr, exp_rv;
      logic [1:0]  f_exp;
      logic [31:0] i_exp;
      int          ar_c, r_c, lat;
      aligned = (pc[1:0] == 2'b00);
      tmo     = aligned && (r_dly >= TMO);
      ar_c    = 1 + ar_dly;
      r_c     = 2 + ar_dly + r_dly;
      lat     = !aligned ? 1 : (tmo ? 2 + ar_dly + TMO : r_c + 1);
      f_exp   = model_fault(pc, r_dly, resp);
      i_exp   = (f_exp == 2'd0) ? data : 32'h0;

      req_valid = 1; req_pc = pc;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL %s req_ready_at_accept got=%b exp=1", name, req_ready);
      end
      @(posedge cpu_clk); #1;
      req_valid = 0; req_pc = $urandom;
      for (int c = 1; c <= lat + hold; c++) begin
         arready    = aligned && (c == ar_c);
         rvalid     = aligned && !tmo && (c == r_c);
         rdata      = (c == r_c) ? data : $urandom;
         rresp      = (c == r_c) ? resp : 2'($urandom);
         resp_ready = (c == lat + hold);
         #1;
         exp_ar = aligned && (c <= ar_c);
         exp_rr = (aligned && c > ar_c && c < lat) || (tmo && c >= lat);
         exp_rv = (c >= lat);
         checks++;
         if (arvalid !== exp_ar) begin
            failures++; $display("FAIL %s arvalid c=%0d got=%b exp=%b", name, c, arvalid, exp_ar);
         end
         if (exp_ar) begin
            checks++;
            if (araddr !== pc) begin
               failures++; $display("FAIL %s araddr c=%0d got=%h exp=%h", name, c, araddr, pc);
            end
         end
         checks++;
         if (rready !== exp_rr) begin
            failures++; $display("FAIL %s rready c=%0d got=%b exp=%b", name, c, rready, exp_rr);
         end
         checks++;
         if (resp_valid !== exp_rv) begin
            failures++; $display("FAIL %s resp_valid c=%0d got=%b exp=%b", name, c, resp_valid, exp_rv);
         end
         if (c >= lat) begin
            checks++;
            if ({resp_inst, resp_pc, resp_fault, req_ready} !== {i_exp, pc, f_exp, 1'b0}) begin
               failures++;
               $display("FAIL %s result c=%0d got inst=%h pc=%h fault=%0d rdy=%b exp inst=%h pc=%h fault=%0d rdy=0",
                        name, c, resp_inst, resp_pc, resp_fault, req_ready, i_exp, pc, f_exp);
            end
         end
         @(posedge cpu_clk); #1;
      end
      idle_inputs();
      #1;
      checks++;
      if ({req_ready, busy, resp_valid} !== {!tmo, tmo, 1'b0}) begin
         failures++;
         $display("FAIL %s after_handshake got rdy=%b busy=%b rv=%b exp rdy=%b busy=%b rv=0",
                  name, req_ready, busy, resp_valid, !tmo, tmo);
      end
   endtask

   task automatic test_basic();
      do_fetch(32'h8000_0000, 0, 0, 32'h0000_0297, 2'b00, 0, "basic");
   endtask

   task automatic test_misaligned();
      do_fetch(32'h8000_0002, 0, 0, 32'h0, 2'b00, 5, "misaligned");
   endtask

   task automatic test_bus_error();
      do_fetch(32'h8000_0020, 1, 1, 32'h1234_5678, 2'b10, 0, "bus_error");
   endtask

   // Table rows: {req_valid, flush, arready, rvalid, resp_ready, expected
   // {arvalid, rready, resp_valid, req_ready, busy}}.
   task automatic test_flush_addr();
      logic [9:0]  tbl [0:7];
      logic [4:0]  obs;
      logic [31:0] pc;
      pc  = 32'h8000_0040;
      tbl = '{10'b10000_00010, 10'b00000_10001, 10'b01000_10001, 10'b00000_10001,
              10'b00100_10001, 10'b00000_01001, 10'b00010_01001, 10'b00000_00010};
      req_pc = pc; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
      for (int c = 0; c < 8; c++) begin
         {req_valid, flush, arready, rvalid, resp_ready} = tbl[c][9:5];
         #1;
         obs = {arvalid, rready, resp_valid, req_ready, busy};
         checks++;
         if (obs !== tbl[c][4:0]) begin
            failures++; $display("FAIL flush_addr c=%0d got=%b exp=%b", c, obs, tbl[c][4:0]);
         end
         if (tbl[c][4]) begin
            checks++;
            if (araddr !== pc) begin
               failures++; $display("FAIL flush_addr araddr c=%0d got=%h exp=%h", c, araddr, pc);
            end
         end
         @(posedge cpu_clk); #1;
      end
      idle_inputs();
   endtask

   task automatic test_flush_data_hold();
      logic [9:0] tbl [0:18];
      logic [4:0] obs;
      tbl = '{
         10'b10000_00010, 10'b00100_10001, 10'b01000_01001, 10'b00000_01001, 10'b00010_01001,
         10'b10000_00010, 10'b00100_10001, 10'b01010_01001,
         10'b10000_00010, 10'b00100_10001, 10'b00010_01001, 10'b01001_00001,
         10'b11000_00000, 10'b00000_00010,
         10'b10000_00010, 10'b00100_10001, 10'b00010_01001, 10'b00001_00101, 10'b00000_00010};
      req_pc = 32'h8000_0200; rdata = 32'h1111_2222; rresp = 2'b00;
      for (int c = 0; c < 19; c++) begin
         {req_valid, flush, arready, rvalid, resp_ready} = tbl[c][9:5];
         #1;
         obs = {arvalid, rready, resp_valid, req_ready, busy};
         checks++;
         if (obs !== tbl[c][4:0]) begin
            failures++; $display("FAIL flush_data_hold c=%0d got=%b exp=%b", c, obs, tbl[c][4:0]);
         end
         @(posedge cpu_clk); #1;
      end
      idle_inputs();
   endtask

   task automatic test_timeout();
      logic [4:0] obs;
      logic [4:0] exp;
      do_fetch(32'h8000_0100, 1, TMO, 32'h0, 2'b00, 0, "timeout");
      @(posedge cpu_clk); #1;
      for (int c = 0; c < 6; c++) begin
         req_valid = (c < 3);
         req_pc    = 32'h8000_0300;
         rvalid    = (c == 3);
         rdata     = 32'hCAFE_F00D;
         #1;
         obs = {arvalid, rready, resp_valid, req_ready, busy};
         exp = (c <= 3) ? 5'b01001 : 5'b00010;
         checks++;
         if (obs !== exp) begin
            failures++; $display("FAIL timeout_stale c=%0d got=%b exp=%b", c, obs, exp);
         end
         @(posedge cpu_clk); #1;
      end
      idle_inputs();
      do_fetch(32'h8000_0304, 0, 1, 32'h0040_0093, 2'b00, 0, "after_timeout");
   endtask

   task automatic test_reset_mid();
      logic [4:0]  obs;
      logic [97:0] obs_d;
      req_valid = 1; req_pc = 32'h8000_0010;
      @(posedge cpu_clk); #1;
      req_valid = 0; arready = 1;
      @(posedge cpu_clk); #1;
      arready = 0;
      #1;
      checks++;
      if (rready !== 1'b1) begin
         failures++; $display("FAIL reset_mid in_data rready got=%b exp=1", rready);
      end
      cpu_rs = 1;
      @(posedge cpu_clk); #1;
      cpu_rs = 0;
      #1;
      obs = {arvalid, rready, resp_valid, req_ready, busy};
      checks++;
      if (obs !== 5'b00010) begin
         failures++; $display("FAIL reset_mid ctrl got=%b exp=%b", obs, 5'b00010);
      end
      obs_d = {resp_inst, resp_pc, resp_fault, araddr};
      checks++;
      if (obs_d !== '0) begin
         failures++; $display("FAIL reset_mid data got=%h exp=0", obs_d);
      end
      @(posedge cpu_clk); #1;
      do_fetch(32'h8000_0004, 0, 0, 32'h0051_3023, 2'b00, 0, "post_reset");
   endtask

   task automatic test_random();
      logic [31:0] pc;
      logic [1:0]  resp;
      for (int i = 0; i < 24; i++) begin
         pc = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
         resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, TMO - 1), $urandom, resp,
                  $urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_misaligned();
      test_bus_error();
      test_flush_addr();
      test_flush_data_hold();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
